// File: rtl/capture_pkg.sv
// Shared definitions for the lidar capture sequencer: FSM state encoding
// and bit positions inside the host command word.
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_UPLOAD  = 2'd2
    } state_e;

    localparam int CMD_START = 0;
    localparam int CMD_ABORT = 1;
    localparam int CMD_CONT  = 2;

    // A further group follows unless this was the last one of a finite sequence.
    function automatic logic seq_continues(input logic cont, input logic unlimited,
                                           input logic below_total);
        return cont | unlimited | below_total;
    endfunction

endpackage

// File: rtl/edge_rise_n.sv
// Registered rising-edge detector. The history register resets to RST_VAL so a
// level already high when reset releases is not reported as an edge.
module edge_rise_n #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    // Track the previous sample and emit a one-cycle registered pulse on 0->1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
        end else begin
            prev_q <= d_i;
            rise_q <= d_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/capture_seq_ctrl.sv
// Acquisition sequencer: gates capture_en, counts laser triggers per group and
// hands each finished group to the uploader before starting the next one.
module capture_seq_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned GRP_W = 16,
    parameter int unsigned CMD_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] ur_cmd,
    input  logic [CNT_W-1:0] total_pulse,
    input  logic [GRP_W-1:0] total_groups,
    input  logic             pulse_in,
    input  logic             upload_done,
    output logic             capture_en,
    output logic [CNT_W-1:0] pulse_count,
    output logic [GRP_W-1:0] group_count,
    output logic             upload_req,
    output logic             busy,
    output logic             seq_done,
    output logic             aborted,
    output logic             overrun
);

    logic             start_p;
    logic             abort_p;
    logic             unused_cmd_s;

    state_e           state_q;
    logic [CNT_W-1:0] total_pulse_q;
    logic [GRP_W-1:0] total_groups_q;
    logic             cont_q;
    logic [CNT_W-1:0] pulse_count_q;
    logic [GRP_W-1:0] group_count_q;
    logic             capture_en_q;
    logic             upload_req_q;
    logic             busy_q;
    logic             seq_done_q;
    logic             aborted_q;
    logic             overrun_q;

    logic             start_ok_d;
    logic             last_pulse_d;
    logic [GRP_W-1:0] group_inc_d;
    logic             more_groups_d;

    edge_rise_n #(.RST_VAL(1'b1)) u_start_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (ur_cmd[CMD_START]),
        .rise_o (start_p)
    );

    edge_rise_n #(.RST_VAL(1'b1)) u_abort_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (ur_cmd[CMD_ABORT]),
        .rise_o (abort_p)
    );

    assign unused_cmd_s = ^ur_cmd[CMD_W-1:CMD_CONT+1];

    // Decision terms; last_pulse_d is only consumed in CAPTURE where total_pulse_q != 0.
    always_comb begin
        start_ok_d    = start_p & ~abort_p & (total_pulse != {CNT_W{1'b0}});
        last_pulse_d  = (pulse_count_q == (total_pulse_q - CNT_W'(1'b1)));
        group_inc_d   = group_count_q + GRP_W'(1'b1);
        more_groups_d = seq_continues(cont_q,
                                      (total_groups_q == {GRP_W{1'b0}}),
                                      (group_inc_d < total_groups_q));
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            total_pulse_q  <= {CNT_W{1'b0}};
            total_groups_q <= {GRP_W{1'b0}};
            cont_q         <= 1'b0;
            pulse_count_q  <= {CNT_W{1'b0}};
            group_count_q  <= {GRP_W{1'b0}};
            capture_en_q   <= 1'b0;
            upload_req_q   <= 1'b0;
            busy_q         <= 1'b0;
            seq_done_q     <= 1'b0;
            aborted_q      <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            seq_done_q <= 1'b0;
            aborted_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok_d) begin
                        total_pulse_q  <= total_pulse;
                        total_groups_q <= total_groups;
                        cont_q         <= ur_cmd[CMD_CONT];
                        pulse_count_q  <= {CNT_W{1'b0}};
                        group_count_q  <= {GRP_W{1'b0}};
                        overrun_q      <= 1'b0;
                        capture_en_q   <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (abort_p) begin
                        capture_en_q <= 1'b0;
                        upload_req_q <= 1'b0;
                        busy_q       <= 1'b0;
                        aborted_q    <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (pulse_in) begin
                        pulse_count_q <= pulse_count_q + CNT_W'(1'b1);
                        if (last_pulse_d) begin
                            capture_en_q <= 1'b0;
                            upload_req_q <= 1'b1;
                            state_q      <= ST_UPLOAD;
                        end
                    end
                end
                ST_UPLOAD: begin
                    if (abort_p) begin
                        capture_en_q <= 1'b0;
                        upload_req_q <= 1'b0;
                        busy_q       <= 1'b0;
                        aborted_q    <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        // Triggers arriving while the uploader drains are flagged, not counted.
                        if (pulse_in) begin
                            overrun_q <= 1'b1;
                        end
                        if (upload_done) begin
                            upload_req_q  <= 1'b0;
                            group_count_q <= group_inc_d;
                            if (more_groups_d) begin
                                pulse_count_q <= {CNT_W{1'b0}};
                                capture_en_q  <= 1'b1;
                                state_q       <= ST_CAPTURE;
                            end else begin
                                seq_done_q <= 1'b1;
                                busy_q     <= 1'b0;
                                state_q    <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    capture_en_q <= 1'b0;
                    upload_req_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign capture_en  = capture_en_q;
    assign pulse_count = pulse_count_q;
    assign group_count = group_count_q;
    assign upload_req  = upload_req_q;
    assign busy        = busy_q;
    assign seq_done    = seq_done_q;
    assign aborted     = aborted_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Scoreboard bench for capture_seq_ctrl: stimulus pushes expected group/done/abort
// events from a sequence-level model; a negedge monitor pops and compares them.
module tb_capture_seq_ctrl;

    localparam int CNT_W = 16;
    localparam int GRP_W = 16;
    localparam int CMD_W = 16;

    localparam int EV_GROUP = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CMD_W-1:0] ur_cmd = '0;
    logic [CNT_W-1:0] total_pulse = '0;
    logic [GRP_W-1:0] total_groups = '0;
    logic             pulse_in = 1'b0;
    logic             upload_done = 1'b0;
    logic             capture_en;
    logic [CNT_W-1:0] pulse_count;
    logic [GRP_W-1:0] group_count;
    logic             upload_req;
    logic             busy;
    logic             seq_done;
    logic             aborted;
    logic             overrun;

    typedef struct {
        int kind;
        int pcount;
        int gcount;
        int ovr;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Sequence-level model: latched config, groups completed, sticky overrun.
    int  m_tp, m_tg, m_cont, m_g, m_ovr;

    capture_seq_ctrl #(.CNT_W(CNT_W), .GRP_W(GRP_W), .CMD_W(CMD_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ur_cmd       (ur_cmd),
        .total_pulse  (total_pulse),
        .total_groups (total_groups),
        .pulse_in     (pulse_in),
        .upload_done  (upload_done),
        .capture_en   (capture_en),
        .pulse_count  (pulse_count),
        .group_count  (group_count),
        .upload_req   (upload_req),
        .busy         (busy),
        .seq_done     (seq_done),
        .aborted      (aborted),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int pc, input int gc, input int ov);
        ev_t e;
        e.kind = kind; e.pcount = pc; e.gcount = gc; e.ovr = ov;
        exp_q.push_back(e);
    endtask

    task automatic handle(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual_kind=%0d required=none at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            check("event_pulse_count", 64'(pulse_count), 64'(e.pcount));
            check("event_group_count", 64'(group_count), 64'(e.gcount));
            check("event_overrun", 64'(overrun), 64'(e.ovr));
            if (kind == EV_GROUP) check("group_capture_en_low", 64'(capture_en), 64'd0);
            else                  check("end_busy_low", 64'(busy), 64'd0);
        end
    endtask

    // Monitor: reacts to every DUT-presented event away from the active edge.
    initial begin
        logic upl_prev;
        upl_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (upload_req && !upl_prev) handle(EV_GROUP);
                if (seq_done)                handle(EV_DONE);
                if (aborted)                 handle(EV_ABORT);
            end
            upl_prev = upload_req;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_pulse();
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
    endtask

    task automatic do_start(input int tp, input int tg, input int cont);
        total_pulse  = CNT_W'(tp);
        total_groups = GRP_W'(tg);
        ur_cmd = '0;
        ur_cmd[2] = cont[0];
        ur_cmd[0] = 1'b1;
        tick();
        check("capture_en_before_start", 64'(capture_en), 64'd0);
        ur_cmd[0] = 1'b0;
        tick();
        if (tp != 0) begin
            m_tp = tp; m_tg = tg; m_cont = cont; m_g = 0; m_ovr = 0;
            check("start_capture_en", 64'(capture_en), 64'd1);
            check("start_busy", 64'(busy), 64'd1);
            check("start_pulse_count", 64'(pulse_count), 64'd0);
            check("start_group_count", 64'(group_count), 64'd0);
            check("start_overrun_clr", 64'(overrun), 64'd0);
        end else begin
            repeat (3) tick();
            check("zero_tp_idle", 64'(busy), 64'd0);
            check("zero_tp_capture_en", 64'(capture_en), 64'd0);
        end
        // Config and mode inputs must be ignored once the sequence is running.
        total_pulse  = CNT_W'($urandom);
        total_groups = GRP_W'($urandom);
        ur_cmd[2]    = 1'($urandom_range(0, 1));
    endtask

    task automatic run_group(input int ovr_inj, input int gap_max, input int ud_delay);
        bit fin;
        for (int i = 0; i < m_tp; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            if (i == m_tp - 1) push_ev(EV_GROUP, m_tp, m_g, m_ovr);
            send_pulse();
        end
        check("upload_req_set", 64'(upload_req), 64'd1);
        check("upload_capture_en", 64'(capture_en), 64'd0);
        if (ovr_inj != 0) begin
            send_pulse();
            m_ovr = 1;
            check("overrun_set", 64'(overrun), 64'd1);
            check("overrun_pcount_hold", 64'(pulse_count), 64'(m_tp));
        end
        repeat (ud_delay) tick();
        check("upload_req_held", 64'(upload_req), 64'd1);
        m_g++;
        fin = (m_cont == 0) && (m_tg != 0) && (m_g == m_tg);
        if (fin) push_ev(EV_DONE, m_tp, m_g, m_ovr);
        upload_done = 1'b1;
        tick();
        upload_done = 1'b0;
        check("after_upload_busy", 64'(busy), 64'(!fin));
        check("after_upload_req", 64'(upload_req), 64'd0);
        check("after_upload_group", 64'(group_count), 64'(m_g));
        check("after_upload_pcount", 64'(pulse_count), fin ? 64'(m_tp) : 64'd0);
    endtask

    task automatic abort_in_capture(input int k);
        for (int i = 0; i < k; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_pulse();
        end
        push_ev(EV_ABORT, k, m_g, m_ovr);
        ur_cmd[1] = 1'b1;
        tick();
        ur_cmd[1] = 1'b0;
        tick();
        check("abort_capture_en", 64'(capture_en), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_upload_req", 64'(upload_req), 64'd0);
        check("abort_pcount_hold", 64'(pulse_count), 64'(k));
    endtask

    initial begin
        int tp, tg, cont, n;

        // Reset with start held high: outputs zero, and release must not start.
        ur_cmd[0]    = 1'b1;
        total_pulse  = CNT_W'(3);
        total_groups = GRP_W'(1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_capture_en", 64'(capture_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulse_count", 64'(pulse_count), 64'd0);
        check("rst_group_count", 64'(group_count), 64'd0);
        check("rst_upload_req", 64'(upload_req), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        check("held_start_no_busy", 64'(busy), 64'd0);
        ur_cmd = '0;
        repeat (2) tick();
        check("held_start_release_idle", 64'(busy), 64'd0);

        // Single group.
        do_start(4, 1, 0);
        run_group(0, 0, 3);

        // Three groups.
        do_start(2, 3, 0);
        repeat (3) run_group(0, 1, 1);

        // Continuous mode for five groups, then abort in CAPTURE.
        do_start(2, 2, 1);
        repeat (5) run_group(0, 1, 1);
        check("cont_group_count", 64'(group_count), 64'd5);
        abort_in_capture(1);

        // Zero pulse count never starts.
        do_start(0, 1, 0);

        // Start and abort rising together: abort wins in IDLE, nothing happens.
        total_pulse = CNT_W'(2);
        ur_cmd = 16'h0003;
        tick();
        ur_cmd = '0;
        repeat (3) tick();
        check("start_abort_busy", 64'(busy), 64'd0);
        check("start_abort_capture_en", 64'(capture_en), 64'd0);

        // Overrun is sticky through seq_done and cleared by the next start.
        do_start(3, 2, 0);
        run_group(1, 0, 2);
        run_group(0, 0, 1);
        check("overrun_after_done", 64'(overrun), 64'd1);
        do_start(1, 1, 0);
        run_group(0, 0, 0);

        // Asynchronous reset mid-CAPTURE.
        do_start(8, 1, 0);
        repeat (3) send_pulse();
        check("pre_reset_pcount", 64'(pulse_count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_capture_en", 64'(capture_en), 64'd0);
        check("async_rst_pcount", 64'(pulse_count), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_no_abort", 64'(aborted), 64'd0);
        check("async_rst_no_done", 64'(seq_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        // Randomized sequences against the model.
        for (int s = 0; s < 20; s++) begin
            tp   = $urandom_range(1, 5);
            tg   = $urandom_range(0, 3);
            cont = $urandom_range(0, 1);
            do_start(tp, tg, cont);
            if (cont != 0 || tg == 0) begin
                n = $urandom_range(1, 4);
                repeat (n) run_group(($urandom_range(0, 3) == 0) ? 1 : 0, 2, $urandom_range(0, 3));
                abort_in_capture($urandom_range(0, tp - 1));
            end else begin
                repeat (tg) run_group(($urandom_range(0, 3) == 0) ? 1 : 0, 2, $urandom_range(0, 3));
            end
            repeat ($urandom_range(1, 3)) tick();
        end

        repeat (5) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
